// File: rtl/lsu_pkg.sv
// lsu_pkg -- op/size codes, FSM states and access-legality helper for the LSU.
// Revision 1.0
`default_nettype none

package lsu_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10,
      OP_RSVD  = 2'b11
   } lsu_op_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } lsu_size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } lsu_state_t;

   // Illegal size or an address not aligned to the access width.
   function automatic logic bad_access(input lsu_size_t size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_ext.sv
// lsu_load_ext -- selects the addressed lane of a read word and sign/zero-extends it.
// Revision 1.0
`default_nettype none

module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  lsu_size_t   size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata[{offset, 3'b000} +: 8];
      lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
         SZ_HALF: data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
         default: data = rdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// lsu -- load/store unit: one outstanding memory access, IDLE/REQ/WAIT/DONE handshake FSM.
// Revision 1.0
`default_nettype none

module lsu
   import lsu_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_err
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   lsu_state_t        state, state_nxt;
   lsu_op_t           req_op, op_q;
   lsu_size_t         req_size, size_q;
   logic              unsigned_q;
   logic [31:0]       addr_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic              accept, is_mem, req_bad, timeout;
   logic [3:0]        st_mask;
   logic [31:0]       st_wdata;
   logic [31:0]       load_data;

   assign req_op        = lsu_op_t'(in_op);
   assign req_size      = lsu_size_t'(in_size);
   assign in_ready      = (state == ST_IDLE);
   assign accept        = in_valid & in_ready;
   assign is_mem        = (req_op == OP_LOAD) || (req_op == OP_STORE);
   assign req_bad       = bad_access(req_size, in_addr[1:0]);
   assign timeout       = (wait_cnt == CNT_W'(MAX_WAIT - 1));
   assign mem_req_valid = (state == ST_REQ);
   assign out_valid     = (state == ST_DONE);

   always_comb begin
      st_mask  = 4'b1111;
      st_wdata = in_wdata;
      case (req_size)
         SZ_BYTE: begin
            st_mask  = 4'b0001 << in_addr[1:0];
            st_wdata = {4{in_wdata[7:0]}};
         end
         SZ_HALF: begin
            st_mask  = 4'b0011 << in_addr[1:0];
            st_wdata = {2{in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   lsu_load_ext u_load_ext (
      .rdata       (mem_rsp_rdata),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .data        (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = (is_mem && !req_bad) ? ST_REQ : ST_DONE;
         ST_REQ:  if (mem_req_ready) state_nxt = ST_WAIT;
         ST_WAIT: if (mem_rsp_valid || timeout) state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q          <= OP_NONE;
         size_q        <= SZ_BYTE;
         unsigned_q    <= 1'b0;
         addr_q        <= '0;
         wait_cnt      <= '0;
         mem_req_wen   <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
         out_data      <= '0;
         out_err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op_q          <= req_op;
               size_q        <= req_size;
               unsigned_q    <= in_unsigned;
               addr_q        <= in_addr;
               mem_req_wen   <= (req_op == OP_STORE);
               mem_req_addr  <= {in_addr[31:2], 2'b00};
               mem_req_wdata <= (req_op == OP_STORE) ? st_wdata : 32'h0;
               mem_req_wmask <= (req_op == OP_STORE) ? st_mask  : 4'h0;
               out_data      <= is_mem ? 32'h0 : in_addr;
               out_err       <= is_mem & req_bad;
            end
            ST_REQ: if (mem_req_ready) wait_cnt <= '0;
            ST_WAIT: begin
               if (mem_rsp_valid) begin
                  // Store responses carry no data; report the address instead.
                  out_data <= (op_q == OP_STORE) ? addr_q : load_data;
                  out_err  <= 1'b0;
               end else if (timeout) begin
                  out_data <= '0;
                  out_err  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
